ram_mp: RTL and testbench

//  Parametrised N-port synchronous RAM, successor to the fixed two-port RAM.
//  - Generic in NPORTS, depth, data width and byte lanes; all ports share one clock.
//  - Adds per-port byte enables, read-valid tracking and configurable read latency.
//  - Adds selectable read-during-write mode and deterministic write-collision resolution.
//  - Sits between bus adapters / DMA channels and shared on-chip buffer storage.

---
 rtl/ram_mp_pkg.sv | 18 +
 rtl/ram_mp_wr_arb.sv | 84 ++++++++
 rtl/ram_mp.sv | 146 ++++++++++++++
 tb/tb_ram_mp.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_mp_pkg.sv
// ram_mp_pkg: shared types and helpers for the multi-port RAM.
//  - rdw_mode_e : read-during-write behaviour selector
//  - lanes()    : number of byte lanes in a data word
//  - MAX_PORTS  : largest supported port count
package ram_mp_pkg;

  localparam int MAX_PORTS = 8;

  typedef enum logic [0:0] {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  function automatic int lanes(input int dwid);
    return dwid / 8;
  endfunction

endpackage

// File: rtl/ram_mp_wr_arb.sv
// ram_mp_wr_arb: per-lane priority resolution of concurrent write requests.
//  Ports
//   clk, rst      : clock, asynchronous active-high reset
//   wr_req        : qualified write request per port (enabled, write, address in range)
//   be, addr,
//   wdata         : packed per-port byte enables, addresses and write data
//   mrg_data      : per port p, merged word of every writer targeting addr[p]
//   mrg_mask      : per port p, lanes written at addr[p] this cycle
//   winner        : port p is the lowest-index writer of its address (commits the word)
//   wr_collision  : registered, port lost at least one overlapping lane last cycle
module ram_mp_wr_arb
  import ram_mp_pkg::*;
#(
  parameter int NPORTS = 2,
  parameter int AWID   = 8,
  parameter int DWID   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPORTS-1:0]            wr_req,
  input  logic [NPORTS*(DWID/8)-1:0]   be,
  input  logic [NPORTS*AWID-1:0]       addr,
  input  logic [NPORTS*DWID-1:0]       wdata,
  output logic [NPORTS*DWID-1:0]       mrg_data,
  output logic [NPORTS*(DWID/8)-1:0]   mrg_mask,
  output logic [NPORTS-1:0]            winner,
  output logic [NPORTS-1:0]            wr_collision
);

  localparam int LANES = lanes(DWID);

  logic [NPORTS*DWID-1:0]  mrg_data_s;
  logic [NPORTS*LANES-1:0] mrg_mask_s;
  logic [NPORTS-1:0]       winner_s;
  logic [NPORTS-1:0]       lost_s;
  logic [NPORTS-1:0]       coll_r;
  logic                    hit_s;
  logic                    offer_s;
  logic                    taken_s;

  // Merge all writers that share each port's address; scanning q upward makes
  // the lowest-index port claim a lane first, later offers of that lane lose.
  always_comb begin
    mrg_data_s = '0;
    mrg_mask_s = '0;
    winner_s   = '0;
    lost_s     = '0;
    hit_s      = 1'b0;
    offer_s    = 1'b0;
    taken_s    = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      winner_s[p] = wr_req[p];
      for (int q = 0; q < NPORTS; q++) begin
        hit_s = wr_req[q] & (addr[q*AWID +: AWID] == addr[p*AWID +: AWID]);
        winner_s[p] = winner_s[p] & ~(hit_s & (q < p));
        for (int k = 0; k < LANES; k++) begin
          offer_s = hit_s & be[q*LANES + k];
          taken_s = mrg_mask_s[p*LANES + k];
          // Only port p's own offer against an already-claimed lane marks p as loser.
          lost_s[p] = lost_s[p] | (offer_s & taken_s & (q == p));
          mrg_data_s[p*DWID + k*8 +: 8] = (offer_s & ~taken_s) ?
                                          wdata[q*DWID + k*8 +: 8] :
                                          mrg_data_s[p*DWID + k*8 +: 8];
          mrg_mask_s[p*LANES + k] = taken_s | offer_s;
        end
      end
    end
  end

  // Collision flags are reported one cycle after the conflicting writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_r <= '0;
    end else begin
      coll_r <= lost_s;
    end
  end

  assign mrg_data     = mrg_data_s;
  assign mrg_mask     = mrg_mask_s;
  assign winner       = winner_s;
  assign wr_collision = coll_r;

endmodule

// File: rtl/ram_mp.sv
// ram_mp: parametrised N-port synchronous RAM on a single clock.
//  Ports (port p occupies slice p of each packed bus)
//   clk, rst      : clock, asynchronous active-high reset
//   en, we        : access request and write select per port
//   be            : byte enables, DWID/8 per port
//   addr, wdata   : address and write data per port
//   rdata, rvalid : read data and one-cycle valid strobe, RD_LAT cycles after the request
//   wr_collision  : port lost an overlapping same-address write last cycle
//   addr_err      : access with addr >= DEPTH was dropped last cycle
//  Memory contents are not reset; only the read pipe and status flags are.
module ram_mp
  import ram_mp_pkg::*;
#(
  parameter int NPORTS   = 2,
  parameter int DEPTH    = 256,
  parameter int AWID     = 8,
  parameter int DWID     = 16,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NPORTS-1:0]            en,
  input  logic [NPORTS-1:0]            we,
  input  logic [NPORTS*(DWID/8)-1:0]   be,
  input  logic [NPORTS*AWID-1:0]       addr,
  input  logic [NPORTS*DWID-1:0]       wdata,
  output logic [NPORTS*DWID-1:0]       rdata,
  output logic [NPORTS-1:0]            rvalid,
  output logic [NPORTS-1:0]            wr_collision,
  output logic [NPORTS-1:0]            addr_err
);

  localparam int   LANES  = lanes(DWID);
  localparam int   IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic BYPASS = (RDW_MODE == int'(RDW_WRITE_FIRST));

  logic [DWID-1:0]         mem_r [0:DEPTH-1];
  logic [NPORTS-1:0]       in_rng_s;
  logic [NPORTS-1:0]       wr_req_s;
  logic [NPORTS-1:0]       rd_req_s;
  logic [NPORTS*DWID-1:0]  mrg_data_s;
  logic [NPORTS*LANES-1:0] mrg_mask_s;
  logic [NPORTS-1:0]       winner_s;
  logic [NPORTS*DWID-1:0]  rd_word_s;
  logic [NPORTS*DWID-1:0]  s1_data_r;
  logic [NPORTS-1:0]       s1_vld_r;
  logic [NPORTS-1:0]       addr_err_r;

  // Address range check and request qualification; no modulo wrap on addr.
  always_comb begin
    in_rng_s = '0;
    for (int p = 0; p < NPORTS; p++) begin
      in_rng_s[p] = (32'(addr[p*AWID +: AWID]) < DEPTH);
    end
    wr_req_s = en & we & in_rng_s;
    rd_req_s = en & ~we;
  end

  ram_mp_wr_arb #(
    .NPORTS (NPORTS),
    .AWID   (AWID),
    .DWID   (DWID)
  ) u_wr_arb (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req_s),
    .be           (be),
    .addr         (addr),
    .wdata        (wdata),
    .mrg_data     (mrg_data_s),
    .mrg_mask     (mrg_mask_s),
    .winner       (winner_s),
    .wr_collision (wr_collision)
  );

  // Commit each distinct address once, from its lowest-index writer, so two
  // ports never drive the same word in one cycle.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++) begin
      for (int k = 0; k < LANES; k++) begin
        if (winner_s[p] && mrg_mask_s[p*LANES + k]) begin
          mem_r[addr[p*AWID +: IDX_W]][k*8 +: 8] <= mrg_data_s[p*DWID + k*8 +: 8];
        end
      end
    end
  end

  // Read word per port: zero when out of range; in write-first mode lanes being
  // written by another port at the same address take the new data.
  always_comb begin
    rd_word_s = '0;
    for (int p = 0; p < NPORTS; p++) begin
      rd_word_s[p*DWID +: DWID] = in_rng_s[p] ? mem_r[addr[p*AWID +: IDX_W]] : {DWID{1'b0}};
      for (int k = 0; k < LANES; k++) begin
        rd_word_s[p*DWID + k*8 +: 8] = (BYPASS && mrg_mask_s[p*LANES + k]) ?
                                       mrg_data_s[p*DWID + k*8 +: 8] :
                                       rd_word_s[p*DWID + k*8 +: 8];
      end
    end
  end

  // First read stage and address-error flags; read data holds between reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_data_r  <= '0;
      s1_vld_r   <= '0;
      addr_err_r <= '0;
    end else begin
      s1_vld_r   <= rd_req_s;
      addr_err_r <= en & ~in_rng_s;
      for (int p = 0; p < NPORTS; p++) begin
        if (rd_req_s[p]) begin
          s1_data_r[p*DWID +: DWID] <= rd_word_s[p*DWID +: DWID];
        end
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic [NPORTS*DWID-1:0] s2_data_r;
      logic [NPORTS-1:0]      s2_vld_r;

      // Extra output register; holds naturally because stage one holds.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          s2_data_r <= '0;
          s2_vld_r  <= '0;
        end else begin
          s2_data_r <= s1_data_r;
          s2_vld_r  <= s1_vld_r;
        end
      end

      assign rdata  = s2_data_r;
      assign rvalid = s2_vld_r;
    end else begin : g_lat1
      assign rdata  = s1_data_r;
      assign rvalid = s1_vld_r;
    end
  endgenerate

  assign addr_err = addr_err_r;

endmodule

// File: tb/tb_ram_mp.sv
// tb_ram_mp: self-checking bench for ram_mp.
//  dut_a : 2 ports, DEPTH=200, RD_LAT=2, read-first
//  dut_b : 2 ports, DEPTH=200, RD_LAT=1, write-first (same stimulus as dut_a)
//  dut_c : 4 ports, DEPTH=256, RD_LAT=1, used for the throughput run
module tb_ram_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  en2, we2;
  logic [3:0]  be2;
  logic [15:0] addr2;
  logic [31:0] wdata2;
  logic [31:0] a_rdata, b_rdata;
  logic [1:0]  a_rvalid, b_rvalid, a_coll, b_coll, a_aerr, b_aerr;
  logic [3:0]  c_en, c_we, c_rvalid, c_coll, c_aerr;
  logic [7:0]  c_be;
  logic [31:0] c_addr;
  logic [63:0] c_wdata, c_rdata;

  always #5 clk = ~clk;

  ram_mp #(.NPORTS(2), .DEPTH(200), .AWID(8), .DWID(16), .RD_LAT(2), .RDW_MODE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en2), .we(we2), .be(be2), .addr(addr2), .wdata(wdata2),
    .rdata(a_rdata), .rvalid(a_rvalid), .wr_collision(a_coll), .addr_err(a_aerr));

  ram_mp #(.NPORTS(2), .DEPTH(200), .AWID(8), .DWID(16), .RD_LAT(1), .RDW_MODE(1)) dut_b (
    .clk(clk), .rst(rst), .en(en2), .we(we2), .be(be2), .addr(addr2), .wdata(wdata2),
    .rdata(b_rdata), .rvalid(b_rvalid), .wr_collision(b_coll), .addr_err(b_aerr));

  ram_mp #(.NPORTS(4), .DEPTH(256), .AWID(8), .DWID(16), .RD_LAT(1), .RDW_MODE(0)) dut_c (
    .clk(clk), .rst(rst), .en(c_en), .we(c_we), .be(c_be), .addr(c_addr), .wdata(c_wdata),
    .rdata(c_rdata), .rvalid(c_rvalid), .wr_collision(c_coll), .addr_err(c_aerr));

  typedef struct {
    logic [1:0]  en, we;
    logic [3:0]  be;
    logic [7:0]  a0, a1;
    logic [15:0] d0, d1;
    logic [15:0] rf0, rf1;   // expected read data, read-first
    logic [15:0] wf0, wf1;   // expected read data, write-first
    logic [1:0]  coll, aerr;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  logic [15:0] qa [2][$];
  logic [15:0] qb [2][$];
  logic [15:0] qc [4][$];
  logic [15:0] last_a [2];
  logic [15:0] last_b [2];
  logic [15:0] last_c [4];
  logic [15:0] cmem [0:63];
  int c_cnt [4];
  int c_first [4];
  int c_last [4];
  int cyc;
  int n_pass, n_total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard pop on rvalid; otherwise rdata must hold (zero while in reset).
  task automatic monitor();
    logic [15:0] e;
    for (int p = 0; p < 2; p++) begin
      if (rst) begin last_a[p] = 16'h0; last_b[p] = 16'h0; end
      if (a_rvalid[p]) begin
        if (qa[p].size() == 0) begin
          n_total++; $display("FAIL a_rvalid%0d: pulse with no read outstanding", p);
        end else begin
          e = qa[p].pop_front(); check($sformatf("a_rdata%0d", p), 64'(a_rdata[p*16 +: 16]), 64'(e)); last_a[p] = e;
        end
      end else check($sformatf("a_hold%0d", p), 64'(a_rdata[p*16 +: 16]), 64'(last_a[p]));
      if (b_rvalid[p]) begin
        if (qb[p].size() == 0) begin
          n_total++; $display("FAIL b_rvalid%0d: pulse with no read outstanding", p);
        end else begin
          e = qb[p].pop_front(); check($sformatf("b_rdata%0d", p), 64'(b_rdata[p*16 +: 16]), 64'(e)); last_b[p] = e;
        end
      end else check($sformatf("b_hold%0d", p), 64'(b_rdata[p*16 +: 16]), 64'(last_b[p]));
    end
    for (int p = 0; p < 4; p++) begin
      if (rst) last_c[p] = 16'h0;
      if (c_rvalid[p]) begin
        c_cnt[p]++;
        if (c_cnt[p] == 1) c_first[p] = cyc;
        c_last[p] = cyc;
        if (qc[p].size() == 0) begin
          n_total++; $display("FAIL c_rvalid%0d: pulse with no read outstanding", p);
        end else begin
          e = qc[p].pop_front(); check($sformatf("c_rdata%0d", p), 64'(c_rdata[p*16 +: 16]), 64'(e)); last_c[p] = e;
        end
      end else check($sformatf("c_hold%0d", p), 64'(c_rdata[p*16 +: 16]), 64'(last_c[p]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    monitor();
  endtask

  initial begin
    //          en     we     be       a0     a1     d0        d1        rf0       rf1       wf0       wf1       coll   aerr
    vecs[0]  = '{2'b01, 2'b01, 4'b0011, 8'h10, 8'h00, 16'hBEEF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00};
    vecs[1]  = '{2'b10, 2'b00, 4'b0000, 8'h00, 8'h10, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000, 16'hBEEF, 2'b00, 2'b00};
    vecs[2]  = '{2'b01, 2'b01, 4'b0011, 8'h05, 8'h00, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00};
    vecs[3]  = '{2'b01, 2'b01, 4'b0010, 8'h05, 8'h00, 16'hABCD, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00};
    vecs[4]  = '{2'b10, 2'b00, 4'b0000, 8'h00, 8'h05, 16'h0000, 16'h0000, 16'h0000, 16'hAB34, 16'h0000, 16'hAB34, 2'b00, 2'b00};
    vecs[5]  = '{2'b11, 2'b11, 4'b0111, 8'h20, 8'h20, 16'h1111, 16'h2222, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b10, 2'b00};
    vecs[6]  = '{2'b11, 2'b00, 4'b0000, 8'h20, 8'h20, 16'h0000, 16'h0000, 16'h1111, 16'h1111, 16'h1111, 16'h1111, 2'b00, 2'b00};
    vecs[7]  = '{2'b11, 2'b11, 4'b1001, 8'h30, 8'h30, 16'h00AA, 16'hBB00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00};
    vecs[8]  = '{2'b01, 2'b00, 4'b0000, 8'h30, 8'h00, 16'h0000, 16'h0000, 16'hBBAA, 16'h0000, 16'hBBAA, 16'h0000, 2'b00, 2'b00};
    vecs[9]  = '{2'b11, 2'b11, 4'b1100, 8'h40, 8'h40, 16'h9999, 16'h4321, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00};
    vecs[10] = '{2'b01, 2'b00, 4'b0000, 8'h40, 8'h00, 16'h0000, 16'h0000, 16'h4321, 16'h0000, 16'h4321, 16'h0000, 2'b00, 2'b00};
    vecs[11] = '{2'b01, 2'b01, 4'b0011, 8'h07, 8'h00, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00};
    vecs[12] = '{2'b11, 2'b01, 4'b0011, 8'h07, 8'h07, 16'h00FF, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h00FF, 2'b00, 2'b00};
    vecs[13] = '{2'b10, 2'b00, 4'b0000, 8'h00, 8'h07, 16'h0000, 16'h0000, 16'h0000, 16'h00FF, 16'h0000, 16'h00FF, 2'b00, 2'b00};
    vecs[14] = '{2'b11, 2'b10, 4'b1000, 8'h07, 8'h07, 16'h0000, 16'hEE00, 16'h00FF, 16'h0000, 16'hEEFF, 16'h0000, 2'b00, 2'b00};
    vecs[15] = '{2'b11, 2'b11, 4'b1111, 8'h00, 8'hC7, 16'h0000, 16'h0C0C, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00};
    vecs[16] = '{2'b01, 2'b01, 4'b0011, 8'hC8, 8'h00, 16'h5555, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b01};
    vecs[17] = '{2'b11, 2'b00, 4'b0000, 8'hC7, 8'h00, 16'h0000, 16'h0000, 16'h0C0C, 16'h0000, 16'h0C0C, 16'h0000, 2'b00, 2'b00};
    vecs[18] = '{2'b11, 2'b00, 4'b0000, 8'hFF, 8'hC8, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b11};
    vecs[19] = '{2'b00, 2'b00, 4'b0000, 8'h00, 8'h00, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b00, 2'b00};
    vecs[20] = '{2'b11, 2'b00, 4'b0000, 8'h10, 8'h20, 16'h0000, 16'h0000, 16'hBEEF, 16'h1111, 16'hBEEF, 16'h1111, 2'b00, 2'b00};
    vecs[21] = '{2'b11, 2'b00, 4'b0000, 8'h07, 8'h30, 16'h0000, 16'h0000, 16'hEEFF, 16'hBBAA, 16'hEEFF, 16'hBBAA, 2'b00, 2'b00};

    n_pass = 0; n_total = 0; cyc = 0;
    for (int p = 0; p < 2; p++) begin last_a[p] = 16'h0; last_b[p] = 16'h0; end
    for (int p = 0; p < 4; p++) begin last_c[p] = 16'h0; c_cnt[p] = 0; c_first[p] = 0; c_last[p] = 0; end
    rst = 1'b1;
    en2 = 2'b00; we2 = 2'b00; be2 = 4'b0000; addr2 = 16'h0000; wdata2 = 32'h0;
    c_en = 4'h0; c_we = 4'h0; c_be = 8'h00; c_addr = 32'h0; c_wdata = 64'h0;

    // Reset state
    tick();
    tick();
    check("rst_a_out", {a_rdata, 4'h0, a_rvalid, a_coll, a_aerr}, 64'h0);
    check("rst_b_out", {b_rdata, 4'h0, b_rvalid, b_coll, b_aerr}, 64'h0);
    check("rst_c_flags", {48'h0, c_rvalid, c_coll, c_aerr, 4'h0}, 64'h0);
    check("rst_c_rdata", c_rdata, 64'h0);
    rst = 1'b0;
    tick();

    // Table-driven vectors, one per cycle, reads pipelined back to back
    for (int i = 0; i < NV; i++) begin
      en2 = vecs[i].en; we2 = vecs[i].we; be2 = vecs[i].be;
      addr2 = {vecs[i].a1, vecs[i].a0}; wdata2 = {vecs[i].d1, vecs[i].d0};
      for (int p = 0; p < 2; p++) begin
        if (vecs[i].en[p] && !vecs[i].we[p]) begin
          qa[p].push_back((p == 0) ? vecs[i].rf0 : vecs[i].rf1);
          qb[p].push_back((p == 0) ? vecs[i].wf0 : vecs[i].wf1);
        end
      end
      tick();
      check($sformatf("v%0d_a_coll", i), 64'(a_coll), 64'(vecs[i].coll));
      check($sformatf("v%0d_b_coll", i), 64'(b_coll), 64'(vecs[i].coll));
      check($sformatf("v%0d_a_aerr", i), 64'(a_aerr), 64'(vecs[i].aerr));
      check($sformatf("v%0d_b_aerr", i), 64'(b_aerr), 64'(vecs[i].aerr));
    end
    en2 = 2'b00;
    repeat (3) tick();
    check("ab_drained", 64'(qa[0].size() + qa[1].size() + qb[0].size() + qb[1].size()), 64'h0);

    // Reset mid-read: p0 reads 0x10 while p1 writes 0x7777@0x50, then reset
    // lands between stage one and stage two of dut_a.
    en2 = 2'b11; we2 = 2'b10; be2 = 4'b1100; addr2 = {8'h50, 8'h10}; wdata2 = {16'h7777, 16'h0000};
    qb[0].push_back(16'hBEEF);
    tick();
    en2 = 2'b00; we2 = 2'b00;
    #2 rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (4) tick();
    check("midrst_a_rvalid", 64'(a_rvalid), 64'h0);
    check("midrst_a_rdata", 64'(a_rdata), 64'h0);
    // The write accepted just before reset stays committed
    en2 = 2'b10; we2 = 2'b00; addr2 = {8'h50, 8'h00};
    qa[1].push_back(16'h7777); qb[1].push_back(16'h7777);
    tick();
    en2 = 2'b00;
    repeat (3) tick();
    check("midrst_drained", 64'(qa[0].size() + qa[1].size() + qb[0].size() + qb[1].size()), 64'h0);

    // Throughput on dut_c: fill 64 words, then 64 back-to-back reads per port
    for (int i = 0; i < 16; i++) begin
      c_en = 4'hF; c_we = 4'hF; c_be = 8'hFF;
      for (int p = 0; p < 4; p++) begin
        c_addr[p*8 +: 8] = 8'(i*4 + p);
        c_wdata[p*16 +: 16] = 16'($urandom);
        cmem[i*4 + p] = c_wdata[p*16 +: 16];
      end
      tick();
      check($sformatf("c_wr%0d_flags", i), {56'h0, c_coll, c_aerr}, 64'h0);
    end
    for (int i = 0; i < 64; i++) begin
      c_en = 4'hF; c_we = 4'h0;
      for (int p = 0; p < 4; p++) begin
        c_addr[p*8 +: 8] = 8'((i*4 + p*17) % 64);
        qc[p].push_back(cmem[(i*4 + p*17) % 64]);
      end
      tick();
    end
    c_en = 4'h0;
    repeat (3) tick();
    for (int p = 0; p < 4; p++) begin
      check($sformatf("c_pulses%0d", p), 64'(c_cnt[p]), 64'd64);
      check($sformatf("c_span%0d", p), 64'(c_last[p] - c_first[p]), 64'd63);
      check($sformatf("c_drained%0d", p), 64'(qc[p].size()), 64'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
